eth_tx_arbiter: RTL and testbench
=================================

# eth_tx_arbiter

Shares a single Ethernet framer between `NUM_REQ` payload sources such as ARP and IPv4 senders. The arbiter grants one requester at a time in round-robin order and latches that requester's destination MAC and ethertype for the whole frame. It forwards the granted payload stream to the framer's payload input. It holds the grant until the framer reports that the complete frame, including CRC, has left its output. It sits directly upstream of the framer, inside the MAC transmit path.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters; legal range 2..8.
- `IFG_CYCLES`, 12, idle cycles enforced between frames; used only when `ETH_TX_ARB_IFG_EN` is defined.

Ports:
- `clk`  in  1  single clock; everything is synchronous to it.
- `sreset`  in  1  synchronous reset, active-high.
- `req_axis_tready`  out  NUM_REQ  per-requester payload ready.
- `req_axis_tvalid`  in  NUM_REQ  per-requester payload valid; also acts as the request.
- `req_axis_tlast`  in  NUM_REQ  per-requester last payload byte.
- `req_axis_tdata`  in  NUM_REQ*8  per-requester payload byte; requester i occupies bits [8i+7:8i].
- `req_dst_mac`  in  NUM_REQ*48  per-requester destination MAC.
- `req_ethertype`  in  NUM_REQ*16  per-requester ethertype.
- `payload_axis_tready`  in  1  framer payload ready.
- `payload_axis_tvalid`  out  1  framer payload valid.
- `payload_axis_tlast`  out  1  framer payload last.
- `payload_axis_tdata`  out  8  framer payload byte.
- `dst_mac`  out  48  latched destination MAC for the framer.
- `ethertype`  out  16  latched ethertype for the framer.
- `frame_done`  in  1  framer output handshake on its final beat (tvalid & tready & tlast).
- `grant_idx`  out  max(1,$clog2(NUM_REQ))  index of the current or most recent grant.
- `busy`  out  1  high in every state except IDLE.

## Operation
- State machine: IDLE, PASS, WAIT_DONE, and GAP (GAP exists only when the macro is defined).
- IDLE:
  - If any `req_axis_tvalid` bit is set, select the first set bit searching from `ptr+1` and wrapping modulo NUM_REQ.
  - Register that index into `grant_idx`, and `ptr`.
  - Latch the requester's `req_dst_mac` and `req_ethertype`.
  - Move to PASS.
- PASS:
  - Combinational mux: `payload_axis_{tvalid,tlast,tdata}` = `req_axis_*[grant_idx]`.
  - `req_axis_tready[grant_idx]` = `payload_axis_tready`; all other tready bits are 0.
  - A handshake with tlast=1 moves the machine to WAIT_DONE.
- WAIT_DONE:
  - All `req_axis_tready` bits are 0 and `payload_axis_tvalid` is 0.
  - On `frame_done`, go to GAP if the macro is defined, otherwise go to IDLE.
  - `frame_done` is ignored in every state except WAIT_DONE.
- GAP: a counter loads IFG_CYCLES-1 on entry and decrements each cycle; the machine moves to IDLE when the counter reaches 0.
- `dst_mac` and `ethertype` change only on the IDLE→PASS transition. They are stable from the first payload beat until the next grant.
- Requests that drop while the arbiter is not in IDLE are not remembered. Only the requests present in the IDLE cycle are arbitrated.
- Outside PASS, `payload_axis_tvalid` is 0 and `payload_axis_tlast`/`tdata` are 0.

## Timing
- Reset values:
  - State = IDLE.
  - `ptr` = NUM_REQ-1, so requester 0 wins first.
  - `grant_idx` = 0, `busy` = 0.
  - `dst_mac` = 0, `ethertype` = 0.
  - All `req_axis_tready` bits = 0.
  - `payload_axis_tvalid`/`tlast`/`tdata` = 0.
- Grant latency: a request seen in IDLE at cycle N gives PASS at N+1. The first payload beat can transfer at N+1.
- Pass-through has zero latency, with no register stage. No byte is dropped or duplicated under any pattern of ready/valid stalls.
- Frame turnaround, from `frame_done` in cycle M:
  - Without the macro, IDLE at M+1 and the next grant at M+2.
  - With the macro, GAP occupies M+1..M+IFG_CYCLES, IDLE is at M+IFG_CYCLES+1, and the next grant is at M+IFG_CYCLES+2.
- Simultaneous requests: round-robin guarantees each active requester is served within NUM_REQ grants.
- A single-byte payload (tvalid & tlast in the first PASS cycle) goes straight to WAIT_DONE.
- `sreset` asserted in any state returns the machine to the reset values on the next edge. A partially forwarded frame is abandoned, and the framer is reset by the same signal.

## Configuration
- Macro: `ETH_TX_ARB_IFG_EN`.
- Defined: the GAP state and a $clog2(IFG_CYCLES+1)-bit counter are built. At least IFG_CYCLES idle cycles are guaranteed after each `frame_done` before the next grant.
- Undefined: no GAP state and no counter. WAIT_DONE goes directly to IDLE, and `IFG_CYCLES` is unused.

## Test plan
- **Single requester:** reset, then requester 0 sends 4 bytes 0x01..0x04 with dst_mac 0x0A0B0C0D0E0F and ethertype 0x0800. The framer payload carries 01,02,03,04 with tlast on 04. `dst_mac` and `ethertype` hold those values, and `grant_idx` = 0.
- **Round-robin fairness:** with NUM_REQ=3, requesters 0, 1 and 2 each present frames continuously. Grants follow the order 0,1,2,0,1,2, and each frame's MAC matches its source.
- **Backpressure:** `payload_axis_tready` is toggled at random (50%) during a 64-byte frame. The output byte sequence is identical to the input, and non-granted tready bits stay 0 throughout.
- **Done gating:** `frame_done` is held off for 20 cycles after payload tlast, while requester 1 keeps requesting. No grant occurs and `busy` = 1 until `frame_done`, then the next grant follows at the latency in Timing.
- **IFG (macro defined, IFG_CYCLES=12):** `frame_done` at cycle M with a pending request. The next grant lands at M+14, and `busy` stays high through M+12.
- **Mid-frame reset:** `sreset` is pulsed after 3 of 10 bytes. The next cycle shows all outputs at their reset values, and the first request after reset goes to requester 0.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing one Ethernet framer between NUM_REQ payload sources.
// Define ETH_TX_ARB_IFG_EN to build a GAP state that holds IFG_CYCLES idle cycles after each frame.
module eth_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int IFG_CYCLES = 12,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    sreset,
  // Streams: a beat moves on a cycle where tvalid and tready are both high; a source must
  // hold tvalid and its data/tlast until that cycle, and tvalid never depends on tready.
  output logic [NUM_REQ-1:0]      req_axis_tready,
  input  logic [NUM_REQ-1:0]      req_axis_tvalid,
  input  logic [NUM_REQ-1:0]      req_axis_tlast,
  input  logic [NUM_REQ*8-1:0]    req_axis_tdata,
  input  logic [NUM_REQ*48-1:0]   req_dst_mac,
  input  logic [NUM_REQ*16-1:0]   req_ethertype,
  input  logic                    payload_axis_tready,
  output logic                    payload_axis_tvalid,
  output logic                    payload_axis_tlast,
  output logic [7:0]              payload_axis_tdata,
  output logic [47:0]             dst_mac,
  output logic [15:0]             ethertype,
  input  logic                    frame_done,
  output logic [GW-1:0]           grant_idx,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || IFG_CYCLES < 1) begin : g_param_check
    $error("eth_tx_arbiter: NUM_REQ must be 2..8 and IFG_CYCLES at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PASS      = 2'd1,
    S_WAIT_DONE = 2'd2
`ifdef ETH_TX_ARB_IFG_EN
    , S_GAP     = 2'd3
`endif
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_grant_idx;
  logic [47:0]     r_dst_mac;
  logic [15:0]     r_ethertype;

  logic            w_sel_vld;
  logic [GW-1:0]   w_sel_idx;
  logic [47:0]     w_sel_mac;
  logic [15:0]     w_sel_et;
  logic            w_g_valid;
  logic            w_g_last;
  logic [7:0]      w_g_data;

`ifdef ETH_TX_ARB_IFG_EN
  localparam int CW = $clog2(IFG_CYCLES + 1);
  logic [CW-1:0]   r_ifg_cnt;
`endif

  // Rotating priority: search starts just after the previous winner and wraps.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = r_ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_sel_vld && req_axis_tvalid[i] && (((int'(r_ptr) + k) % NUM_REQ) == i)) begin
          w_sel_vld = 1'b1;
          w_sel_idx = GW'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_mac = '0;
    w_sel_et  = '0;
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel_idx == GW'(i)) begin
        w_sel_mac = req_dst_mac[48*i +: 48];
        w_sel_et  = req_ethertype[16*i +: 16];
      end
      if (r_grant_idx == GW'(i)) begin
        w_g_valid = req_axis_tvalid[i];
        w_g_last  = req_axis_tlast[i];
        w_g_data  = req_axis_tdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_sel_vld) w_state_nxt = S_PASS;
      S_PASS:      if (w_g_valid && w_g_last && payload_axis_tready) w_state_nxt = S_WAIT_DONE;
`ifdef ETH_TX_ARB_IFG_EN
      S_WAIT_DONE: if (frame_done) w_state_nxt = S_GAP;
      S_GAP:       if (r_ifg_cnt == '0) w_state_nxt = S_IDLE;
`else
      S_WAIT_DONE: if (frame_done) w_state_nxt = S_IDLE;
`endif
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Zero-latency pass-through; everything is forced low outside PASS.
  always_comb begin
    req_axis_tready     = '0;
    payload_axis_tvalid = 1'b0;
    payload_axis_tlast  = 1'b0;
    payload_axis_tdata  = '0;
    if (r_state == S_PASS) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_grant_idx == GW'(i)) req_axis_tready[i] = payload_axis_tready;
      end
      payload_axis_tvalid = w_g_valid;
      payload_axis_tlast  = w_g_last;
      payload_axis_tdata  = w_g_data;
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state     <= S_IDLE;
      r_ptr       <= GW'(NUM_REQ - 1);
      r_grant_idx <= '0;
      r_dst_mac   <= '0;
      r_ethertype <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_sel_vld) begin
        r_ptr       <= w_sel_idx;
        r_grant_idx <= w_sel_idx;
        r_dst_mac   <= w_sel_mac;
        r_ethertype <= w_sel_et;
      end
    end
  end

`ifdef ETH_TX_ARB_IFG_EN
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_ifg_cnt <= '0;
    end else if (r_state == S_WAIT_DONE && frame_done) begin
      r_ifg_cnt <= CW'(IFG_CYCLES - 1);
    end else if (r_state == S_GAP && r_ifg_cnt != '0) begin
      r_ifg_cnt <= r_ifg_cnt - 1'b1;
    end
  end
`endif

  assign dst_mac   = r_dst_mac;
  assign ethertype = r_ethertype;
  assign grant_idx = r_grant_idx;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomized bench for eth_tx_arbiter: frame-level reference model, expected-byte queue, final report.
module tb_eth_tx_arbiter;
  localparam int NUM_REQ    = 3;
  localparam int IFG_CYCLES = 12;
  localparam int GW         = $clog2(NUM_REQ);
`ifdef ETH_TX_ARB_IFG_EN
  localparam int GAP = IFG_CYCLES;
`else
  localparam int GAP = 0;
`endif

  logic                  clk;
  logic                  sreset;
  logic [NUM_REQ-1:0]    req_axis_tready;
  logic [NUM_REQ-1:0]    req_axis_tvalid;
  logic [NUM_REQ-1:0]    req_axis_tlast;
  logic [NUM_REQ*8-1:0]  req_axis_tdata;
  logic [NUM_REQ*48-1:0] req_dst_mac;
  logic [NUM_REQ*16-1:0] req_ethertype;
  logic                  payload_axis_tready;
  logic                  payload_axis_tvalid;
  logic                  payload_axis_tlast;
  logic [7:0]            payload_axis_tdata;
  logic [47:0]           dst_mac;
  logic [15:0]           ethertype;
  logic                  frame_done;
  logic [GW-1:0]         grant_idx;
  logic                  busy;
  logic [1:0]            dbg_state;

  eth_tx_arbiter #(.NUM_REQ(NUM_REQ), .IFG_CYCLES(IFG_CYCLES)) dut (
    .clk                 (clk),
    .sreset              (sreset),
    .req_axis_tready     (req_axis_tready),
    .req_axis_tvalid     (req_axis_tvalid),
    .req_axis_tlast      (req_axis_tlast),
    .req_axis_tdata      (req_axis_tdata),
    .req_dst_mac         (req_dst_mac),
    .req_ethertype       (req_ethertype),
    .payload_axis_tready (payload_axis_tready),
    .payload_axis_tvalid (payload_axis_tvalid),
    .payload_axis_tlast  (payload_axis_tlast),
    .payload_axis_tdata  (payload_axis_tdata),
    .dst_mac             (dst_mac),
    .ethertype           (ethertype),
    .frame_done          (frame_done),
    .grant_idx           (grant_idx),
    .busy                (busy),
    .dbg_state           (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // source frames
  logic [7:0]         frm [NUM_REQ][64];
  int                 frm_len [NUM_REQ];
  int                 frm_pos [NUM_REQ];
  int                 gap_left [NUM_REQ];
  logic [47:0]        frm_mac [NUM_REQ];
  logic [15:0]        frm_et [NUM_REQ];
  logic [NUM_REQ-1:0] src_en;
  int                 max_gap;
  int                 rdy_pct;
  int                 fd_cnt;

  // reference model: owner of the framer, bytes still owed, cycle it becomes free again
  int          m_owner;
  int          m_left;
  int          m_ptr;
  int          m_grant;
  int          m_rel;
  logic [47:0] m_mac;
  logic [15:0] m_et;
  logic [8:0]  exp_q[$];

  int                 cyc;
  int                 n_checks;
  int                 n_fail;
  logic [NUM_REQ-1:0] s_rdy;
  logic               s_pv;
  logic               s_pl;
  logic [7:0]         s_pd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_frame(input int i);
    int r;
    r = int'($urandom_range(0, 9));
    frm_len[i] = (r == 0) ? 64 : (r == 1) ? 1 : int'($urandom_range(2, 8));
    for (int k = 0; k < 64; k++) frm[i][k] = 8'($urandom);
    frm_mac[i] = {16'($urandom), 32'($urandom)};
    frm_et[i]  = 16'($urandom);
    frm_pos[i] = 0;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_ptr   = NUM_REQ - 1;
    m_grant = 0;
    m_rel   = 0;
    m_mac   = '0;
    m_et    = '0;
    exp_q.delete();
    fd_cnt  = -1;
  endtask

  // Advance model and sources across one rising edge, using the values held during the cycle.
  task automatic on_edge();
    logic [8:0] e;
    int g;
    bit found;
    if (sreset) begin
      model_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
        new_frame(i);
        gap_left[i] = 0;
      end
    end else begin
      if (s_pv && payload_axis_tready) begin
        if (exp_q.size() == 0) check("sink_unexpected_beat", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("sink_beat", 64'({s_pl, s_pd}), 64'(e));
        end
      end
      if (m_owner < 0 && cyc >= m_rel) begin
        found = 1'b0;
        g = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (!found && req_axis_tvalid[(m_ptr + k) % NUM_REQ]) begin
            g = (m_ptr + k) % NUM_REQ;
            found = 1'b1;
          end
        end
        if (found) begin
          m_owner = g;
          m_ptr   = g;
          m_grant = g;
          m_mac   = frm_mac[g];
          m_et    = frm_et[g];
          m_left  = frm_len[g] - frm_pos[g];
          for (int k = frm_pos[g]; k < frm_len[g]; k++)
            exp_q.push_back({(k == frm_len[g] - 1), frm[g][k]});
        end
      end else if (m_owner >= 0 && m_left > 0) begin
        if (req_axis_tvalid[m_owner] && payload_axis_tready) begin
          m_left--;
          if (m_left == 0) fd_cnt = ($urandom_range(0, 5) == 0) ? 20 : int'($urandom_range(0, 3));
        end
      end else if (m_owner >= 0) begin
        if (frame_done) begin
          m_owner = -1;
          m_rel   = cyc + 1 + GAP;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_axis_tvalid[i] && s_rdy[i]) begin
          frm_pos[i]++;
          if (frm_pos[i] == frm_len[i]) begin
            new_frame(i);
            gap_left[i] = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
          end else begin
            gap_left[i] = (max_gap > 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_dst_mac[48*i +: 48]   = frm_mac[i];
      req_ethertype[16*i +: 16] = frm_et[i];
      if (src_en[i] && gap_left[i] == 0) begin
        req_axis_tvalid[i]     = 1'b1;
        req_axis_tlast[i]      = (frm_pos[i] == frm_len[i] - 1);
        req_axis_tdata[8*i +: 8] = frm[i][frm_pos[i]];
      end else begin
        req_axis_tvalid[i]     = 1'b0;
        req_axis_tlast[i]      = 1'($urandom);
        req_axis_tdata[8*i +: 8] = 8'($urandom);
        if (gap_left[i] > 0) gap_left[i]--;
      end
    end
    payload_axis_tready = (int'($urandom_range(1, 100)) <= rdy_pct);
    frame_done = 1'b0;
    if (fd_cnt == 0) begin
      frame_done = 1'b1;
      fd_cnt = -1;
    end else if (fd_cnt > 0) begin
      fd_cnt--;
    end else begin
      frame_done = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic sample_and_check();
    bit idle;
    bit pass;
    int g;
    logic [NUM_REQ-1:0] e_rdy;
    idle = (m_owner < 0) && (cyc >= m_rel);
    pass = (m_owner >= 0) && (m_left > 0);
    g = (m_owner < 0) ? 0 : m_owner;
    e_rdy = '0;
    if (pass && payload_axis_tready) e_rdy[g] = 1'b1;
    check("busy", 64'(busy), 64'(!idle));
    check("grant_idx", 64'(grant_idx), 64'(m_grant));
    check("dst_mac", 64'(dst_mac), 64'(m_mac));
    check("ethertype", 64'(ethertype), 64'(m_et));
    check("req_tready", 64'(req_axis_tready), 64'(e_rdy));
    check("pay_tvalid", 64'(payload_axis_tvalid), 64'(pass ? req_axis_tvalid[g] : 1'b0));
    check("pay_tlast", 64'(payload_axis_tlast), 64'(pass ? req_axis_tlast[g] : 1'b0));
    check("pay_tdata", 64'(payload_axis_tdata), 64'(pass ? req_axis_tdata[8*g +: 8] : 8'h00));
    s_rdy = req_axis_tready;
    s_pv  = payload_axis_tvalid;
    s_pl  = payload_axis_tlast;
    s_pd  = payload_axis_tdata;
  endtask

  task automatic step();
    @(posedge clk);
    on_edge();
    #1;
    drive();
    @(negedge clk);
    sample_and_check();
  endtask

  initial begin
    int waited;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    sreset   = 1'b1;
    src_en   = '0;
    max_gap  = 0;
    rdy_pct  = 100;
    req_axis_tvalid = '0;
    req_axis_tlast  = '0;
    req_axis_tdata  = '0;
    req_dst_mac     = '0;
    req_ethertype   = '0;
    payload_axis_tready = 1'b0;
    frame_done = 1'b0;
    s_rdy = '0;
    s_pv  = 1'b0;
    s_pl  = 1'b0;
    s_pd  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      new_frame(i);
      gap_left[i] = 0;
    end
    model_reset();
    step();
    step();

    // single requester, known frame
    sreset = 1'b0;
    frm_len[0] = 4;
    frm_pos[0] = 0;
    for (int k = 0; k < 4; k++) frm[0][k] = 8'(k + 1);
    frm_mac[0] = 48'h0A0B0C0D0E0F;
    frm_et[0]  = 16'h0800;
    src_en = 3'b001;
    repeat (20) step();

    // continuous requests from all sources
    src_en = 3'b111;
    repeat (200) step();

    // random sources, gaps and backpressure
    for (int r = 0; r < 8; r++) begin
      src_en  = NUM_REQ'($urandom_range(1, 7));
      max_gap = 3;
      rdy_pct = 50;
      repeat (300) step();
    end

    // resets in the middle of a frame
    src_en = 3'b111;
    for (int r = 0; r < 3; r++) begin
      waited = 0;
      while (!(m_owner >= 0 && m_left > 0 && frm_pos[m_owner] >= 3) && waited < 600) begin
        step();
        waited++;
      end
      check("midframe_reached", 64'(waited < 600), 64'(1));
      sreset = 1'b1;
      step();
      sreset = 1'b0;
      repeat (40) step();
    end
    repeat (100) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
